icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl_if.sv | 10 +
 rtl/icache_ctrl.sv | 117 +++++++++++
 tb/tb_icache_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_if.sv
// Instruction-memory block-read bus between icache_ctrl (master) and the backing memory (slave).
interface icache_ctrl_if;
  logic         imem_read;
  logic [5:0]   imem_address;
  logic [127:0] imem_readdata;
  logic         imem_busywait;

  modport master (output imem_read, imem_address, input imem_readdata, imem_busywait);
  modport slave  (input imem_read, imem_address, output imem_readdata, imem_busywait);
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only 8 x 16-byte instruction cache with a three-state refill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_ctrl #(
  parameter logic [31:0] INSTR_NOP = 32'h0000_0000,
  parameter int          NUM_SETS  = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   PC,
  output logic [31:0]   INSTRUCTION,
  output logic          BUSYWAIT,
  icache_ctrl_if.master imem
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t              state, state_nx;
  logic [NUM_SETS-1:0] valid;
  logic [2:0]          tags [NUM_SETS];
  logic [127:0]        data [NUM_SETS];
  logic [5:0]          blk_addr;
  logic [127:0]        blk_buf;
  logic [2:0]          idx;
  logic [2:0]          ptag;
  logic                hit;
  logic                unused_pc;

  assign idx       = PC[6:4];
  assign ptag      = PC[9:7];
  assign hit       = valid[idx] && (tags[idx] == ptag);
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  // Refill always targets the block latched at the miss, not the live PC.
  assign imem.imem_address = blk_addr;

  always_comb begin
    state_nx       = state;
    BUSYWAIT       = 1'b0;
    INSTRUCTION    = INSTR_NOP;
    imem.imem_read = 1'b0;
    if (RESET) begin
      case (state)
        IDLE: begin
          if (hit) begin
            INSTRUCTION = data[idx][{PC[3:2], 5'b0} +: 32];
          end else begin
            BUSYWAIT = 1'b1;
            state_nx = MEM_READ;
          end
        end
        MEM_READ: begin
          BUSYWAIT       = 1'b1;
          imem.imem_read = 1'b1;
          if (!imem.imem_busywait) state_nx = UPDATE;
        end
        UPDATE: begin
          BUSYWAIT = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= state_nx;
      if (state == UPDATE) valid[blk_addr[2:0]] <= 1'b1;
    end
  end

  // Datapath needs no reset: contents are only observed behind a valid bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (state == IDLE && !hit)                      blk_addr <= PC[9:4];
      if (state == MEM_READ && !imem.imem_busywait)   blk_buf  <= imem.imem_readdata;
      if (state == UPDATE) begin
        data[blk_addr[2:0]] <= blk_buf;
        tags[blk_addr[2:0]] <= blk_addr[5:3];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] last_pc;
  logic        last_vld;

  // A hit is counted once per distinct PC; a stalled fetch repeating the same PC is not recounted.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
      last_pc    <= '0;
      last_vld   <= 1'b0;
    end else if (state == IDLE) begin
      if (hit) begin
        if ((!last_vld || PC != last_pc) && hit_count != 16'hFFFF)
          hit_count <= hit_count + 16'd1;
        last_pc  <= PC;
        last_vld <= 1'b1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        last_vld <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: vector table of fetches plus reset-abort and PC-change-mid-refill sequences.
module tb_icache_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  icache_ctrl_if mif();

  icache_ctrl #(.INSTR_NOP(NOP), .NUM_SETS(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PC         (PC),
    .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT   (BUSYWAIT),
    .imem       (mif)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  // Memory model: read data valid in the lat-th request cycle.
  logic [127:0] mem [64];
  int           lat = 5;
  int           cnt = 0;
  logic         rd_q = 1'b0;
  logic [5:0]   addr_q [$];
  logic [31:0]  sb_q [$];

  assign mif.imem_busywait = mif.imem_read && (cnt < lat - 1);
  assign mif.imem_readdata = mem[mif.imem_address];

  always @(posedge CLK) begin
    cnt  <= mif.imem_read ? cnt + 1 : 0;
    rd_q <= mif.imem_read;
    if (mif.imem_read && !rd_q) addr_q.push_back(mif.imem_address);
  end

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [5:0] b;
    logic [1:0] w;
    b = pc[9:4];
    w = pc[3:2];
    if (b == 6'd0 && w == 2'd0) return 32'h0006_000B;
    return {16'hC000, 2'b00, b, 6'b0, w};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive a PC (inputs change at posedge+1), count stall cycles, compare the word when BUSYWAIT drops.
  task automatic fetch(input logic [31:0] pc, input int exp_busy, input string nm);
    int          busy;
    int          nop_err;
    bit          done;
    logic [31:0] exp;
    busy    = 0;
    nop_err = 0;
    done    = 1'b0;
    PC      = pc;
    sb_q.push_back(exp_word(pc));
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (BUSYWAIT) begin
        busy++;
        if (INSTRUCTION !== NOP) nop_err++;
      end else begin
        done = 1'b1;
        exp  = sb_q.pop_front();
        check({nm, "_instr"}, INSTRUCTION, exp);
      end
      @(posedge CLK); #1;
    end
    if (!done) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: BUSYWAIT still high after 200 cycles", nm);
      void'(sb_q.pop_front());
    end
    check({nm, "_busy_cycles"}, busy, exp_busy);
    check({nm, "_nop_while_busy"}, nop_err, 0);
  endtask

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          busy;
    int          pulses;
    logic [5:0]  addr;
  } vec_t;

  vec_t vt [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h000, 5, 7, 1, 6'h00};
    vt[1]  = '{32'h004, 5, 0, 0, 6'h00};
    vt[2]  = '{32'h008, 5, 0, 0, 6'h00};
    vt[3]  = '{32'h00C, 5, 0, 0, 6'h00};
    vt[4]  = '{32'h080, 5, 7, 1, 6'h08};
    vt[5]  = '{32'h000, 5, 7, 1, 6'h00};
    vt[6]  = '{32'h3FC, 5, 7, 1, 6'h3F};
    vt[7]  = '{32'h3F0, 5, 0, 0, 6'h00};
    vt[8]  = '{32'h104, 1, 3, 1, 6'h10};
    vt[9]  = '{32'h008, 1, 3, 1, 6'h00};
    vt[10] = '{32'h3F8, 5, 0, 0, 6'h00};

    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        mem[b][32*w +: 32] = exp_word({22'd0, 6'(b), 2'(w), 2'b00});

    RESET = 1'b0;
    PC    = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("reset_instr", INSTRUCTION, NOP);
    check("reset_imem_read", {31'd0, mif.imem_read}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("reset_hit_count", {16'd0, hit_count}, 32'd0);
    check("reset_miss_count", {16'd0, miss_count}, 32'd0);
`endif
    @(posedge CLK); #1;
    RESET = 1'b1;

    for (int i = 0; i < 11; i++) begin
      lat = vt[i].lat;
      addr_q.delete();
      fetch(vt[i].pc, vt[i].busy, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_read_pulses", i), addr_q.size(), vt[i].pulses);
      if (vt[i].pulses > 0 && addr_q.size() > 0)
        check($sformatf("vec%0d_imem_address", i), {26'd0, addr_q[0]}, {26'd0, vt[i].addr});
`ifdef ICACHE_STATS_EN
      if (i == 3) begin
        check("stats_miss_count", {16'd0, miss_count}, 32'd1);
        check("stats_hit_count", {16'd0, hit_count}, 32'd4);
      end
`endif
    end

    // Reset asserted while a refill is in MEM_READ aborts it and clears every set.
    lat = 5;
    PC  = 32'h040;
    @(negedge CLK);
    check("abort_miss_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort_in_mem_read", {31'd0, mif.imem_read}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("abort_read_during_reset", {31'd0, mif.imem_read}, 32'd0);
    check("abort_busy_during_reset", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort_read_next_cycle", {31'd0, mif.imem_read}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    addr_q.delete();
    fetch(32'h000, 7, "after_reset_pc0");
    fetch(32'h040, 7, "after_reset_pc40");
    check("after_reset_pulses", addr_q.size(), 2);

    // PC moves from 0x10 to 0x20 mid-refill: the 0x10 block still completes, then 0x20 misses.
    addr_q.delete();
    PC = 32'h010;
    repeat (2) begin
      @(negedge CLK);
      @(posedge CLK); #1;
    end
    fetch(32'h020, 12, "pc_change_mid_refill");
    check("pc_change_pulses", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      check("pc_change_addr0", {26'd0, addr_q[0]}, 32'h01);
      check("pc_change_addr1", {26'd0, addr_q[1]}, 32'h02);
    end
    addr_q.delete();
    fetch(32'h014, 0, "set1_filled_hit");
    check("set1_hit_no_read", addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
